// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_pkg
// Description : Shared constants for the PRBS generator/checker: polynomial
//               select encodings, per-polynomial tap/order tables and the
//               checker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    // Width of the LFSR history register (order of the largest polynomial)
    localparam int c_lfsr_w = 31;

    // poly_sel encodings
    localparam logic [1:0] c_poly_prbs7  = 2'b00;
    localparam logic [1:0] c_poly_prbs15 = 2'b01;
    localparam logic [1:0] c_poly_prbs23 = 2'b10;
    localparam logic [1:0] c_poly_prbs31 = 2'b11;

    // Polynomial x^a + x^b + 1 of order N, indexed by poly_sel
    localparam logic [4:0] c_tap_a [0:3] = '{5'd7, 5'd15, 5'd23, 5'd31};
    localparam logic [4:0] c_tap_b [0:3] = '{5'd6, 5'd14, 5'd18, 5'd28};
    localparam logic [4:0] c_order [0:3] = '{5'd7, 5'd15, 5'd23, 5'd31};

    localparam logic [c_lfsr_w-1:0] c_all_ones = '1;

    // Checker states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // Mask covering the low N bits of the LFSR for the selected polynomial
    function automatic logic [c_lfsr_w-1:0] order_mask(input logic [1:0] sel);
        return c_all_ones >> (5'd31 - c_order[sel]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_step.sv
`default_nettype none
// ============================================================================
// Module      : prbs_step
// Description : Combinational WIDTH-step advance of a Fibonacci LFSR.
//               State bit k holds s[n-1-k] (bit 0 is the most recent bit).
//               bits[i] is the predicted sequence bit s[n+i]. With ext_en set
//               the shifted-in bit is taken from ext_bits instead of the
//               feedback, which lets the checker seed itself from rx data.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_step
    import prbs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [c_lfsr_w-1:0] cur_state,
    input  logic [1:0]          poly_sel,
    input  logic                ext_en,
    input  logic [WIDTH-1:0]    ext_bits,
    output logic [WIDTH-1:0]    bits,
    output logic [c_lfsr_w-1:0] nxt_state
);

    logic [4:0]          w_idx_a;
    logic [4:0]          w_idx_b;
    logic [c_lfsr_w-1:0] w_work;
    logic                w_fb;

    // s[n-a] lives at state bit a-1
    assign w_idx_a = c_tap_a[poly_sel] - 5'd1;
    assign w_idx_b = c_tap_b[poly_sel] - 5'd1;

    // Unrolled WIDTH-step recurrence s[n] = s[n-a] ^ s[n-b]
    always_comb begin
        w_work = cur_state;
        w_fb   = 1'b0;
        bits   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_fb    = w_work[w_idx_a] ^ w_work[w_idx_b];
            bits[i] = w_fb;
            w_work  = {w_work[c_lfsr_w-2:0], (ext_en ? ext_bits[i] : w_fb)};
        end
        nxt_state = w_work;
    end

endmodule
`default_nettype wire

// File: rtl/prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Module      : prbs_gen_chk
// Description : PRBS7/15/23/31 pattern generator and self-synchronising
//               checker, WIDTH bits per clock. The seed maps bit k to
//               s[n-1-k], so seed bit 0 is the bit immediately preceding the
//               first generated bit.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           poly_sel_i,
    input  logic [30:0]          seed_i,
    input  logic                 load_i,
    input  logic                 freeze_i,
    input  logic                 inject_err_i,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    input  logic                 chk_en_i,
    input  logic [WIDTH-1:0]     rx_data_i,
    input  logic                 rx_valid_i,
    input  logic                 err_clr_i,
    output logic                 lock_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    // Consecutive-error counter only needs to reach LOSS_THRESH-1
    localparam int c_run_w = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;
    localparam int c_sum_w = CNT_WIDTH + 6;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    // ---------------------------------------------------------------- generator
    logic [c_lfsr_w-1:0] r_gen_state;
    logic [1:0]          r_gen_poly;
    logic                r_inj;
    logic [c_lfsr_w-1:0] w_seed_mask;
    logic [c_lfsr_w-1:0] w_seed_lo;
    logic [c_lfsr_w-1:0] w_seed_ld;
    logic [WIDTH-1:0]    w_gen_bits;
    logic [c_lfsr_w-1:0] w_gen_next;

    // An all-zero seed would lock the LFSR up, so it becomes all-ones
    assign w_seed_mask = order_mask(poly_sel_i);
    assign w_seed_lo   = seed_i & w_seed_mask;
    assign w_seed_ld   = (w_seed_lo == '0) ? w_seed_mask : w_seed_lo;

    prbs_step #(.WIDTH(WIDTH)) u_gen_step (
        .cur_state (r_gen_state),
        .poly_sel  (r_gen_poly),
        .ext_en    (1'b0),
        .ext_bits  ('0),
        .bits      (w_gen_bits),
        .nxt_state (w_gen_next)
    );

    // Generator: load beats freeze; otherwise advance and publish a word.
    // The inject flag only flips the published bit, never the LFSR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gen_state <= c_all_ones;
            r_gen_poly  <= c_poly_prbs7;
            r_inj       <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
        end else begin
            if (load_i) begin
                r_gen_poly  <= poly_sel_i;
                r_gen_state <= w_seed_ld;
                valid_o     <= 1'b0;
            end else if (freeze_i) begin
                valid_o     <= 1'b0;
            end else begin
                r_gen_state <= w_gen_next;
                data_o      <= w_gen_bits ^ WIDTH'(r_inj);
                valid_o     <= 1'b1;
            end
            // A new request re-arms even if the old flag is consumed now
            if (inject_err_i) begin
                r_inj <= 1'b1;
            end else if (!load_i && !freeze_i) begin
                r_inj <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- checker
    chk_state_e          r_chk_state;
    logic [1:0]          r_chk_poly;
    logic [c_lfsr_w-1:0] r_chk_lfsr;
    logic [5:0]          r_seed_cnt;
    logic [c_run_w-1:0]  r_err_run;
    logic [WIDTH-1:0]    w_chk_bits;
    logic [c_lfsr_w-1:0] w_chk_next;
    logic [WIDTH-1:0]    w_miss;
    logic [5:0]          w_pop;
    logic [5:0]          w_seed_need;
    logic [c_sum_w-1:0]  w_sum;
    logic                w_cnt_inc;

    // While seeding, rx bits are shifted straight into the local LFSR;
    // once locked it free-runs and is never reseeded from rx.
    prbs_step #(.WIDTH(WIDTH)) u_chk_step (
        .cur_state (r_chk_lfsr),
        .poly_sel  (r_chk_poly),
        .ext_en    (r_chk_state == ST_SEED),
        .ext_bits  (rx_data_i),
        .bits      (w_chk_bits),
        .nxt_state (w_chk_next)
    );

    assign w_miss      = w_chk_bits ^ rx_data_i;
    assign w_seed_need = 6'((int'(c_order[r_chk_poly]) + WIDTH - 1) / WIDTH);

    // Number of mismatching bits in the current rx word
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + 6'(w_miss[i]);
        end
    end

    // Checker FSM: IDLE -> SEED (latch poly) -> LOCKED, back to SEED on
    // LOSS_THRESH consecutive errored words; disable returns to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_chk_state <= ST_IDLE;
            r_chk_poly  <= c_poly_prbs7;
            r_chk_lfsr  <= '0;
            r_seed_cnt  <= '0;
            r_err_run   <= '0;
            lock_o      <= 1'b0;
        end else if (!chk_en_i) begin
            r_chk_state <= ST_IDLE;
            r_err_run   <= '0;
            lock_o      <= 1'b0;
        end else begin
            case (r_chk_state)
                ST_IDLE: begin
                    r_chk_state <= ST_SEED;
                    r_chk_poly  <= poly_sel_i;
                    r_seed_cnt  <= '0;
                    lock_o      <= 1'b0;
                end
                ST_SEED: begin
                    if (rx_valid_i) begin
                        r_chk_lfsr <= w_chk_next;
                        if (r_seed_cnt < w_seed_need) begin
                            r_seed_cnt <= r_seed_cnt + 6'd1;
                        end else if (w_pop == 6'd0) begin
                            r_chk_state <= ST_LOCKED;
                            r_err_run   <= '0;
                            lock_o      <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rx_valid_i) begin
                        r_chk_lfsr <= w_chk_next;
                        if (w_pop == 6'd0) begin
                            r_err_run <= '0;
                        end else if (r_err_run == c_run_w'(LOSS_THRESH - 1)) begin
                            r_chk_state <= ST_SEED;
                            r_seed_cnt  <= '0;
                            r_err_run   <= '0;
                            lock_o      <= 1'b0;
                        end else begin
                            r_err_run <= r_err_run + 1'b1;
                        end
                    end
                end
                default: begin
                    r_chk_state <= ST_IDLE;
                    lock_o      <= 1'b0;
                end
            endcase
        end
    end

    assign w_cnt_inc = (r_chk_state == ST_LOCKED) && rx_valid_i && chk_en_i;
    assign w_sum     = c_sum_w'(err_cnt_o) + c_sum_w'(w_pop);

    // Saturating bit-error counter; clear wins over a same-cycle increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= '0;
        end else if (w_cnt_inc) begin
            err_cnt_o <= (w_sum > c_sum_w'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_gen_chk
// Description : Self-checking bench for prbs_gen_chk. Expected words come
//               from a bit-history model of s[n] = s[n-a] ^ s[n-b]; error
//               counts come from popcounts of the bench's own rx corruption.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_gen_chk;

    localparam int W = 8;
    localparam int M_A [4] = '{7, 15, 23, 31};
    localparam int M_B [4] = '{6, 14, 18, 28};
    localparam int M_N [4] = '{7, 15, 23, 31};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance: defaults
    logic [1:0]   poly0;
    logic [30:0]  seed0;
    logic         load0, freeze0, inj0, chk_en0, clr0;
    logic [W-1:0] data0, rx_data0, flip0;
    logic         valid0, rx_valid0, lock0;
    logic [15:0]  err0;

    // Saturation instance: 4-bit counter, loss threshold out of reach
    logic [1:0]   poly1;
    logic [30:0]  seed1;
    logic         load1, freeze1, inj1, chk_en1, clr1;
    logic [W-1:0] data1, rx_data1, flip1;
    logic         valid1, rx_valid1, lock1;
    logic [3:0]   err1;

    assign rx_data0  = data0 ^ flip0;
    assign rx_valid0 = valid0;
    assign rx_data1  = data1 ^ flip1;
    assign rx_valid1 = valid1;

    prbs_gen_chk #(.WIDTH(W), .CNT_WIDTH(16), .LOSS_THRESH(4)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .poly_sel_i(poly0), .seed_i(seed0),
        .load_i(load0), .freeze_i(freeze0), .inject_err_i(inj0),
        .data_o(data0), .valid_o(valid0), .chk_en_i(chk_en0),
        .rx_data_i(rx_data0), .rx_valid_i(rx_valid0), .err_clr_i(clr0),
        .lock_o(lock0), .err_cnt_o(err0)
    );

    prbs_gen_chk #(.WIDTH(W), .CNT_WIDTH(4), .LOSS_THRESH(1000)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .poly_sel_i(poly1), .seed_i(seed1),
        .load_i(load1), .freeze_i(freeze1), .inject_err_i(inj1),
        .data_o(data1), .valid_o(valid1), .chk_en_i(chk_en1),
        .rx_data_i(rx_data1), .rx_valid_i(rx_valid1), .err_clr_i(clr1),
        .lock_o(lock1), .err_cnt_o(err1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------------------------------------------------------- model
    bit m_hist[$];   // sequence history, oldest first, newest at the end
    int m_a, m_b;

    function automatic void m_seed(input logic [1:0] sel, input logic [30:0] seed);
        int          n;
        logic [30:0] s;
        n   = M_N[sel];
        m_a = M_A[sel];
        m_b = M_B[sel];
        s   = '0;
        for (int i = 0; i < n; i++) s[i] = seed[i];
        if (s == '0) for (int i = 0; i < n; i++) s[i] = 1'b1;
        m_hist.delete();
        for (int i = n - 1; i >= 0; i--) m_hist.push_back(s[i]);
    endfunction

    function automatic logic [7:0] m_word();
        logic [7:0] w;
        bit         nb;
        int         sz;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            sz   = m_hist.size();
            nb   = m_hist[sz - m_a] ^ m_hist[sz - m_b];
            w[i] = nb;
            m_hist.push_back(nb);
            void'(m_hist.pop_front());
        end
        return w;
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_lock(input int which, input int maxw, input string name);
        int n;
        n = 0;
        while (n < maxw && ((which == 0) ? lock0 : lock1) !== 1'b1) begin
            tick();
            n++;
        end
        check(name, {31'd0, ((which == 0) ? lock0 : lock1)}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [30:0] seed;
        int          nwords;
        logic [7:0]  exp_first;
    } gen_vec_t;

    gen_vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] hold;
        int         e0, e1;
        bit         last_err;

        // Table: polynomial, seed, run length; first word from the model
        vecs[0].sel = 2'd0; vecs[0].seed = 31'd0;           vecs[0].nwords = 12;
        vecs[1].sel = 2'd1; vecs[1].seed = 31'($urandom);   vecs[1].nwords = 20;
        vecs[2].sel = 2'd2; vecs[2].seed = 31'($urandom);   vecs[2].nwords = 20;
        vecs[3].sel = 2'd3; vecs[3].seed = 31'($urandom);   vecs[3].nwords = 20;
        vecs[4].sel = 2'd3; vecs[4].seed = 31'h0;           vecs[4].nwords = 10;
        vecs[5].sel = 2'd1; vecs[5].seed = 31'h7FFF_8000;   vecs[5].nwords = 10;
        for (int v = 0; v < 6; v++) begin
            m_seed(vecs[v].sel, vecs[v].seed);
            vecs[v].exp_first = m_word();
        end

        rst_n = 1'b0;
        poly0 = 2'd0; seed0 = '0; load0 = 0; freeze0 = 0; inj0 = 0; chk_en0 = 0; clr0 = 0; flip0 = '0;
        poly1 = 2'd0; seed1 = '0; load1 = 0; freeze1 = 0; inj1 = 0; chk_en1 = 0; clr1 = 0; flip1 = '0;

        // Reset state
        #13;
        check("rst_data", 32'(data0), 32'h0);
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_lock", {31'd0, lock0}, 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_err_u1", 32'(err1), 32'd0);
        rst_n = 1'b1;

        // Free run from reset: first word is 0x40, then model over two periods
        m_seed(2'd0, 31'h7FFF_FFFF);
        tick();
        check("first_word_const", 32'(data0), 32'h40);
        check("first_valid", {31'd0, valid0}, 32'd1);
        void'(m_word());
        for (int k = 1; k < 254; k++) begin
            tick();
            check($sformatf("prbs7_run[%0d]", k), 32'(data0), 32'(m_word()));
        end

        // Table-driven loads; poly/seed changes after load must be ignored
        for (int v = 0; v < 6; v++) begin
            load0 = 1; poly0 = vecs[v].sel; seed0 = vecs[v].seed;
            tick();
            check($sformatf("vec%0d_load_valid", v), {31'd0, valid0}, 32'd0);
            load0 = 0; poly0 = ~vecs[v].sel; seed0 = 31'($urandom);
            m_seed(vecs[v].sel, vecs[v].seed);
            void'(m_word());
            tick();
            check($sformatf("vec%0d_first", v), 32'(data0), 32'(vecs[v].exp_first));
            check($sformatf("vec%0d_valid", v), {31'd0, valid0}, 32'd1);
            for (int k = 1; k < vecs[v].nwords; k++) begin
                tick();
                check($sformatf("vec%0d_word[%0d]", v, k), 32'(data0), 32'(m_word()));
            end
        end

        // Zero seed, freeze for 3 cycles, then asynchronous reset mid-cycle
        load0 = 1; poly0 = 2'd0; seed0 = '0;
        tick();
        load0 = 0;
        m_seed(2'd0, 31'd0);
        tick(); hold = m_word(); check("frz_pre1", 32'(data0), 32'(hold));
        tick(); hold = m_word(); check("frz_pre2", 32'(data0), 32'(hold));
        freeze0 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz_valid", {31'd0, valid0}, 32'd0);
            check("frz_hold", 32'(data0), 32'(hold));
        end
        freeze0 = 0;
        tick();
        check("frz_resume", 32'(data0), 32'(m_word()));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data", 32'(data0), 32'h0);
        check("async_rst_valid", {31'd0, valid0}, 32'd0);
        #2 rst_n = 1'b1;

        // Generator inject: word after the arming edge has bit 0 inverted
        m_seed(2'd0, 31'h7FFF_FFFF);
        tick(); check("inj_pre", 32'(data0), 32'(m_word()));
        inj0 = 1;
        tick(); check("inj_arm_word", 32'(data0), 32'(m_word()));
        inj0 = 0;
        tick(); check("inj_flipped", 32'(data0), 32'(m_word() ^ 8'h01));
        tick(); check("inj_after", 32'(data0), 32'(m_word()));

        // PRBS15 loopback: lock within 4 words, no errors on a long run
        e0 = 0;
        load0 = 1; poly0 = 2'd1; seed0 = 31'($urandom);
        tick();
        load0 = 0; chk_en0 = 1;
        wait_lock(0, 4, "prbs15_lock");
        poly0 = 2'd2;
        repeat (2000) tick();
        check("prbs15_err_clean", 32'(err0), 32'(e0));
        check("prbs15_still_locked", {31'd0, lock0}, 32'd1);

        // Four fully inverted words: lock lost after the 4th, 32 errors
        flip0 = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            e0 += W;
            check($sformatf("inv_lock[%0d]", k), {31'd0, lock0}, (k < 4) ? 32'd1 : 32'd0);
        end
        flip0 = '0;
        check("inv_err", 32'(err0), 32'(e0));
        wait_lock(0, 6, "inv_relock");
        check("inv_err_after", 32'(err0), 32'd32);

        // Disable keeps the count; clear zeroes it
        chk_en0 = 0;
        tick();
        check("dis_lock", {31'd0, lock0}, 32'd0);
        check("dis_err_kept", 32'(err0), 32'(e0));
        clr0 = 1;
        tick();
        clr0 = 0; e0 = 0;
        check("clr_err", 32'(err0), 32'(e0));

        // PRBS31 locked loop, one injected bit error
        load0 = 1; poly0 = 2'd3; seed0 = 31'($urandom);
        tick();
        load0 = 0; chk_en0 = 1;
        wait_lock(0, 8, "prbs31_lock");
        inj0 = 1;
        tick();
        inj0 = 0;
        repeat (4) tick();
        e0 += 1;
        check("inj_err_count", 32'(err0), 32'(e0));
        check("inj_lock_kept", {31'd0, lock0}, 32'd1);

        // Random sparse corruption (never two errored words in a row)
        last_err = 0;
        for (int i = 0; i < 300; i++) begin
            if (!last_err && $urandom_range(0, 5) == 0) flip0 = 8'($urandom_range(1, 255));
            else                                        flip0 = '0;
            last_err = (flip0 != '0);
            e0 += $countones(flip0);
            tick();
            check($sformatf("rand_err[%0d]", i), 32'(err0), 32'(e0));
        end
        flip0 = '0;
        check("rand_lock", {31'd0, lock0}, 32'd1);

        // Saturation on the 4-bit counter, clear beats a same-cycle error
        e1 = 0;
        chk_en1 = 1;
        wait_lock(1, 6, "sat_lock");
        flip1 = 8'h01;
        for (int i = 0; i < 20; i++) begin
            tick();
            e1 = (e1 + 1 > 15) ? 15 : e1 + 1;
            check($sformatf("sat_err[%0d]", i), 32'(err1), 32'(e1));
        end
        check("sat_lock_kept", {31'd0, lock1}, 32'd1);
        clr1 = 1;
        tick();
        clr1 = 0; e1 = 0;
        check("sat_clr_wins", 32'(err1), 32'(e1));
        tick();
        e1 = 1;
        check("sat_after_clr", 32'(err1), 32'(e1));
        flip1 = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits generated and checked per clock; legal range 1..32.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the error counter.
REQ-003 SHALL have parameter LOSS_THRESH, default 4: number of consecutive errored words that forces relock.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports are listed below.
REQ-005 clk_i  in  1  clock; all state is rising-edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 poly_sel_i  in  2  polynomial: 00 PRBS7 x^7+x^6+1, 01 PRBS15 x^15+x^14+1, 10 PRBS23 x^23+x^18+1, 11 PRBS31 x^31+x^28+1.
REQ-008 seed_i  in  31  generator seed; only the low N bits are used (N = polynomial order).
REQ-009 load_i  in  1  load the seed and latch poly_sel_i into the generator.
REQ-010 freeze_i  in  1  hold generator state and data_o.
REQ-011 inject_err_i  in  1  one-shot inversion of data_o[0] in the next generated word.
REQ-012 data_o  out  WIDTH  generated bits; data_o[0] is the earliest bit in the sequence.
REQ-013 valid_o  out  1  data_o carries a new word this cycle.
REQ-014 chk_en_i  in  1  checker enable.
REQ-015 rx_data_i  in  WIDTH  received bits; same bit order as data_o.
REQ-016 rx_valid_i  in  1  rx_data_i is valid this cycle.
REQ-017 err_clr_i  in  1  synchronous clear of err_cnt_o.
REQ-018 lock_o  out  1  checker is locked.
REQ-019 err_cnt_o  out  CNT_WIDTH  saturating count of bit errors.

Function
REQ-020 The sequence SHALL be Fibonacci: s[n] = s[n-a] XOR s[n-b] for polynomial x^a+x^b+1.
REQ-021 When neither load_i nor freeze_i is asserted, the generator SHALL advance WIDTH steps per cycle and register s[n..n+WIDTH-1] into data_o[0..WIDTH-1], with valid_o=1 one cycle later.
REQ-022 load_i SHALL take priority over freeze_i; while load_i is high, valid_o=0 and the seed and polynomial are captured; generation resumes the cycle after load_i falls.
REQ-023 A loaded seed whose low N bits are all zero SHALL be replaced by all-ones.
REQ-024 While freeze_i is high, valid_o=0 and data_o SHALL hold its value.
REQ-025 inject_err_i SHALL arm a one-shot flag that inverts data_o[0] of the next valid word and is then cleared; the LFSR state itself is never corrupted.
REQ-026 Checker FSM states SHALL be IDLE, SEED and LOCKED.
REQ-027 IDLE -> SEED when chk_en_i=1; the checker latches poly_sel_i on this transition.
REQ-028 SEED: shift rx bits into the local LFSR on each rx_valid_i; after ceil(N/WIDTH) valid words, the next valid word is compared; if it matches, go to LOCKED, otherwise stay in SEED and keep shifting.
REQ-029 LOCKED: on each rx_valid_i, the local LFSR SHALL free-run by WIDTH steps (it is not reseeded from rx) and the mismatch popcount SHALL be added to err_cnt_o, saturating at 2^CNT_WIDTH-1.
REQ-030 In LOCKED, LOSS_THRESH consecutive errored words SHALL cause a transition to SEED with lock_o=0; an error-free word resets the consecutive count.
REQ-031 lock_o SHALL be 1 only in LOCKED and SHALL be registered.
REQ-032 err_cnt_o SHALL increment only in LOCKED.
REQ-033 err_clr_i SHALL win over a same-cycle increment, and err_cnt_o reads 0 the next cycle.
REQ-034 chk_en_i=0 in any state SHALL return the FSM to IDLE next cycle; err_cnt_o SHALL be retained.
REQ-035 A change of poly_sel_i without load_i, or without re-entering SEED, SHALL have no effect.

Reset
REQ-036 Reset SHALL set the generator LFSR to all-ones with polynomial PRBS7, data_o=0, valid_o=0, the inject flag to 0, the FSM to IDLE, lock_o=0, err_cnt_o=0, and the consecutive-error count to 0.
REQ-037 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-038 After reset release, the generator SHALL run from the first rising edge.

Structure
REQ-039 A shared package prbs_pkg SHALL hold the poly_sel encodings, the per-polynomial (a, b, N) constant tables, and the checker state enum.
REQ-040 The WIDTH-step next-state function SHALL be one sub-module, prbs_step, that is combinational and parametrised by WIDTH; it is instantiated once by the generator and once by the checker.

Verification
REQ-041 Reset, WIDTH=8, PRBS7, free run: first valid word = 8'h40, and the word sequence SHALL repeat every 127 words.
REQ-042 Loop data_o to rx_data_i with chk_en_i=1 for PRBS15: lock_o=1 within 4 valid words, and err_cnt_o stays 0 over 10^5 words.
REQ-043 Locked PRBS31 loop, pulse inject_err_i once: err_cnt_o increments by exactly 1 and lock_o stays 1.
REQ-044 Locked loop, invert rx for 4 words: lock_o=0 after the 4th word; the checker relocks after the inversion ends; err_cnt_o=32 for WIDTH=8.
REQ-045 CNT_WIDTH=4, continuous errors while locked with LOSS_THRESH large: err_cnt_o saturates at 15; err_clr_i asserted in the same cycle as an error gives err_cnt_o=0.
REQ-046 load_i with seed_i=0, then freeze_i for 3 cycles, then assert rst_ni mid-word: the output after load equals the all-ones-seed sequence; data_o holds during freeze; reset values appear asynchronously.
